// File: rtl/sysbus_mux.sv
// sysbus_mux: two-master (fetch / data-memory) multiplexer onto the single
// external system bus. Round-robin arbitration at IDLE; the winner owns the
// bus for one full transaction (address beat plus LINE_BEATS data or
// response beats). The datapath is a pure mux steered by the FSM state, so
// every output is zero whenever the FSM is idle or in reset.
module sysbus_mux #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  // fetch master
  input  logic                      i_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_req,
  input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
  output logic                      i_reqack,
  output logic                      i_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] i_resp,
  output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
  input  logic                      i_respack,
  output logic                      i_busgrant,
  // data-memory master
  input  logic                      d_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] d_req,
  input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
  output logic                      d_reqack,
  output logic                      d_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] d_resp,
  output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
  input  logic                      d_respack,
  output logic                      d_busgrant,
  // external system bus
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int CW = $clog2(LINE_BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;
  typedef enum logic {M_I, M_D} mst_t;

  state_t        state;
  mst_t          owner;
  mst_t          last;
  mst_t          winner;
  logic          is_read;
  logic [CW-1:0] cnt;

  logic                      req_phase;
  logic                      resp_phase;
  logic                      own_d;
  logic                      o_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] o_req;
  logic [BUS_TAG_WIDTH-1:0]  o_reqtag;
  logic                      o_respack;
  logic                      req_hs;
  logic                      resp_hs;

  // Owner selection: only the owner's request/response-ack reaches the bus.
  assign own_d     = (owner == M_D);
  assign o_reqcyc  = own_d ? d_reqcyc  : i_reqcyc;
  assign o_req     = own_d ? d_req     : i_req;
  assign o_reqtag  = own_d ? d_reqtag  : i_reqtag;
  assign o_respack = own_d ? d_respack : i_respack;

  // is_read is redundant with RESP but keeps a stale RESP from ever opening
  // the response path for a write.
  assign req_phase  = (state == ADDR) || (state == WDATA);
  assign resp_phase = (state == RESP) && is_read;

  // Request path: owner's beat out, bus ack back to the owner only.
  assign bus_reqcyc = req_phase & o_reqcyc;
  assign bus_req    = req_phase ? o_req    : '0;
  assign bus_reqtag = req_phase ? o_reqtag : '0;
  assign i_reqack   = req_phase & ~own_d & bus_reqack;
  assign d_reqack   = req_phase &  own_d & bus_reqack;

  // Response path: beats steered to the owner; stray beats never acked.
  assign bus_respack = resp_phase & o_respack;
  assign i_respcyc   = resp_phase & ~own_d & bus_respcyc;
  assign d_respcyc   = resp_phase &  own_d & bus_respcyc;
  assign i_resp      = resp_phase ? bus_resp    : '0;
  assign d_resp      = resp_phase ? bus_resp    : '0;
  assign i_resptag   = resp_phase ? bus_resptag : '0;
  assign d_resptag   = resp_phase ? bus_resptag : '0;

  assign i_busgrant = (state != IDLE) & ~own_d;
  assign d_busgrant = (state != IDLE) &  own_d;

  assign req_hs  = bus_reqcyc  & bus_reqack;
  assign resp_hs = bus_respcyc & bus_respack;

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  assign winner = (i_reqcyc && d_reqcyc) ? ((last == M_I) ? M_D : M_I)
                                         : (i_reqcyc ? M_I : M_D);

  // Transaction FSM: grant, address beat, then write data or read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= M_I;
      last    <= M_D;
      is_read <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_reqcyc || d_reqcyc) begin
            owner <= winner;
            last  <= winner;
            cnt   <= '0;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (req_hs) begin
            is_read <= bus_reqtag[BUS_TAG_WIDTH-1];
            state   <= bus_reqtag[BUS_TAG_WIDTH-1] ? RESP : WDATA;
          end
        end
        WDATA: begin
          if (req_hs) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= IDLE;
          end
        end
        RESP: begin
          if (resp_hs) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mux.sv
// Bench for sysbus_mux. The bench plays both masters and the external bus
// slave; a transaction-level model (per-master phase, beat count,
// round-robin pointer) predicts ownership and what each port must show.
`timescale 1ns/1ps
module tb_sysbus_mux;
  localparam int W = 64, T = 13, LB = 8;
  localparam int I = 0, D = 1;
  localparam int P_DONE = 0, P_WAIT = 1, P_ADDR = 2, P_WDATA = 3, P_RESP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // bench-driven inputs
  logic [1:0]   reqcyc = '0, respack = '0;
  logic [W-1:0] req [2];
  logic [T-1:0] reqtag [2];
  logic         bus_reqack = 1'b0, bus_respcyc = 1'b0;
  logic [W-1:0] bus_resp = '0;
  logic [T-1:0] bus_resptag = '0;

  // DUT outputs
  logic i_reqack, i_respcyc, i_busgrant, d_reqack, d_respcyc, d_busgrant;
  logic [W-1:0] i_resp, d_resp, bus_req;
  logic [T-1:0] i_resptag, d_resptag, bus_reqtag;
  logic bus_reqcyc, bus_respack;

  logic [1:0]   reqack_o, respcyc_o;
  logic [W-1:0] resp_o [2];
  logic [T-1:0] resptag_o [2];
  logic [8+3*W+3*T-1:0] all_out;
  assign reqack_o  = {d_reqack, i_reqack};
  assign respcyc_o = {d_respcyc, i_respcyc};
  assign resp_o[0] = i_resp;
  assign resp_o[1] = d_resp;
  assign resptag_o[0] = i_resptag;
  assign resptag_o[1] = d_resptag;
  assign all_out = {i_reqack, i_respcyc, i_resp, i_resptag, i_busgrant,
                    d_reqack, d_respcyc, d_resp, d_resptag, d_busgrant,
                    bus_reqcyc, bus_req, bus_reqtag, bus_respack};

  sysbus_mux #(.BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T), .LINE_BEATS(LB)) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(reqcyc[0]), .i_req(req[0]), .i_reqtag(reqtag[0]), .i_reqack(i_reqack),
    .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag), .i_respack(respack[0]),
    .i_busgrant(i_busgrant),
    .d_reqcyc(reqcyc[1]), .d_req(req[1]), .d_reqtag(reqtag[1]), .d_reqack(d_reqack),
    .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag), .d_respack(respack[1]),
    .d_busgrant(d_busgrant),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  int checks = 0, failures = 0, cyc = 0;

  // transaction model state
  int phase [2], dly [2], beat [2], stall_cnt [2];
  bit rd [2];
  logic [W-1:0] addr [2];
  logic [W-1:0] wdat [2][LB];
  logic [W-1:0] got [2][$];
  logic [W-1:0] exp_r [2][$];
  logic [W-1:0] wlog [2][$];
  logic [W-1:0] slv_q [$];
  bit slv_busy;
  int last_m;
  logic [1:0] prev_g, prev_rc, g_now;
  bit final_prev;
  int grant_log [$], grant_cyc [$], fin_log [$];
  logic [W-1:0] grant_req;

  // stimulus knobs and statistics
  int reqack_mode, respack_mode;
  bit gaps, stray, seq_data, alt;
  int stall_seen, respack_seen, stray_seen, resp_beats, stop_after;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      phase[m] = P_DONE; reqcyc[m] = 1'b0; respack[m] = 1'b0;
      req[m] = '0; reqtag[m] = '0;
    end
    slv_q.delete(); slv_busy = 0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    prev_g = '0; prev_rc = '0; final_prev = 0; last_m = D;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input int m, input bit r, input logic [W-1:0] a, input int delay);
    logic [T-2:0] tg;
    tg = T'($urandom);
    phase[m] = P_WAIT; dly[m] = delay; rd[m] = r; addr[m] = a;
    beat[m] = 0; stall_cnt[m] = 0;
    reqtag[m] = {r, tg};
    for (int k = 0; k < LB; k++) wdat[m][k] = {$urandom, $urandom};
    got[m].delete(); exp_r[m].delete(); wlog[m].delete();
  endtask

  // One call drives masters and slave cycle by cycle and compares every
  // DUT output against what the transaction model says it must be.
  task automatic run(input int budget, input int min_cyc);
    int n, o, x, w;
    logic [1:0] eg;
    bit fin;
    n = 0;
    while (n < budget && (n < min_cyc || phase[0] != P_DONE || phase[1] != P_DONE) &&
           !(stop_after > 0 && resp_beats >= stop_after)) begin
      @(negedge clk);
      n++; cyc++;
      for (int m = 0; m < 2; m++) begin
        if (phase[m] == P_WAIT) begin
          if (dly[m] == 0) phase[m] = P_ADDR; else dly[m]--;
        end
        reqcyc[m] = (phase[m] == P_ADDR || phase[m] == P_WDATA);
        if (phase[m] == P_ADDR) req[m] = addr[m];
        else if (phase[m] == P_WDATA) req[m] = wdat[m][beat[m]];
        else if (phase[m] != P_WAIT) begin
          req[m] = {$urandom, $urandom}; reqtag[m] = T'($urandom);
        end
        case (respack_mode)
          0: respack[m] = 1'b1;
          1: if (phase[m] == P_RESP && beat[m] == 3 && stall_cnt[m] < 3) begin
               respack[m] = 1'b0; stall_cnt[m]++;
             end else respack[m] = 1'b1;
          default: respack[m] = ($urandom_range(0, 2) != 0);
        endcase
      end
      case (reqack_mode)
        0: bus_reqack = 1'b1;
        1: begin alt = !alt; bus_reqack = alt; end
        default: bus_reqack = 1'($urandom_range(0, 1));
      endcase
      if (slv_q.size() > 0) begin
        if (!slv_busy) begin
          bus_respcyc = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          bus_resptag = T'($urandom);
          slv_busy = bus_respcyc;
        end
        bus_resp = slv_q[0];
      end else begin
        slv_busy = 0;
        bus_respcyc = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_resp = {$urandom, $urandom};
        bus_resptag = T'($urandom);
      end
      #1;
      fin = 0;
      g_now = {d_busgrant, i_busgrant};
      respack_seen += int'(bus_respack);
      // expected ownership from the arbitration rules
      if (prev_g == 2'b00) begin
        if (prev_rc == 2'b00) eg = 2'b00;
        else begin
          w = (prev_rc == 2'b11) ? ((last_m == I) ? D : I) : (prev_rc[D] ? D : I);
          eg = 2'b01 << w;
          last_m = w;
          grant_log.push_back(w); grant_cyc.push_back(cyc);
          grant_req = bus_req;
        end
      end else eg = final_prev ? 2'b00 : prev_g;
      checks++;
      if (g_now !== eg) begin
        failures++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, g_now, eg);
      end
      if (eg == 2'b00) begin
        if (bus_respcyc) stray_seen++;
        checks++;
        if ({bus_reqcyc, bus_req, bus_reqtag, reqack_o, respcyc_o, bus_respack} !== '0) begin
          failures++;
          $display("FAIL idle_outputs cyc=%0d reqcyc=%b req=%h tag=%h reqack=%b respcyc=%b respack=%b exp all 0",
                   cyc, bus_reqcyc, bus_req, bus_reqtag, reqack_o, respcyc_o, bus_respack);
        end
      end else begin
        o = eg[1] ? D : I;
        x = 1 - o;
        if (phase[o] == P_ADDR || phase[o] == P_WDATA) begin
          checks++;
          if (bus_reqcyc !== 1'b1 || bus_req !== req[o] || bus_reqtag !== reqtag[o]) begin
            failures++;
            $display("FAIL req_pass cyc=%0d got cyc=%b req=%h tag=%h exp 1 %h %h",
                     cyc, bus_reqcyc, bus_req, bus_reqtag, req[o], reqtag[o]);
          end
          checks++;
          if (reqack_o[o] !== bus_reqack || reqack_o[x] !== 1'b0) begin
            failures++;
            $display("FAIL reqack cyc=%0d owner=%0d got=%b bus_reqack=%b", cyc, o, reqack_o, bus_reqack);
          end
          checks++;
          if (respcyc_o !== 2'b00 || bus_respack !== 1'b0) begin
            failures++;
            $display("FAIL resp_in_req cyc=%0d respcyc=%b respack=%b exp 0", cyc, respcyc_o, bus_respack);
          end
          if (bus_reqack) begin
            if (phase[o] == P_ADDR) begin
              beat[o] = 0;
              if (rd[o]) begin
                phase[o] = P_RESP;
                for (int k = 0; k < LB; k++) begin
                  slv_q.push_back(seq_data ? W'(k) : {$urandom, $urandom});
                  exp_r[o].push_back(slv_q[slv_q.size() - 1]);
                end
              end else phase[o] = P_WDATA;
            end else begin
              wlog[o].push_back(bus_req);
              beat[o]++;
              if (beat[o] == LB) begin phase[o] = P_DONE; fin = 1; end
            end
          end
        end else if (phase[o] == P_RESP) begin
          checks++;
          if ({bus_reqcyc, bus_req, bus_reqtag, reqack_o} !== '0) begin
            failures++;
            $display("FAIL req_in_resp cyc=%0d reqcyc=%b req=%h reqack=%b exp 0", cyc, bus_reqcyc, bus_req, reqack_o);
          end
          checks++;
          if (respcyc_o[o] !== bus_respcyc || respcyc_o[x] !== 1'b0 || bus_respack !== respack[o]) begin
            failures++;
            $display("FAIL resp_steer cyc=%0d owner=%0d respcyc=%b respack=%b exp cyc=%b ack=%b",
                     cyc, o, respcyc_o, bus_respack, bus_respcyc, respack[o]);
          end
          if (bus_respcyc) begin
            checks++;
            if (resp_o[o] !== bus_resp || resptag_o[o] !== bus_resptag) begin
              failures++;
              $display("FAIL resp_data cyc=%0d got=%h/%h exp=%h/%h", cyc, resp_o[o], resptag_o[o], bus_resp, bus_resptag);
            end
            if (!bus_respack) stall_seen++;
          end
          if (bus_respcyc && respack[o]) begin
            got[o].push_back(resp_o[o]);
            void'(slv_q.pop_front());
            slv_busy = 0;
            beat[o]++; resp_beats++;
            if (beat[o] == LB) begin phase[o] = P_DONE; fin = 1; end
          end
        end else begin
          checks++; failures++;
          $display("FAIL owner_phase cyc=%0d owner=%0d phase=%0d exp active", cyc, o, phase[o]);
        end
      end
      if (fin) fin_log.push_back(cyc);
      prev_g = eg; prev_rc = reqcyc; final_prev = fin;
    end
  endtask

  task automatic set_modes(input int ra, input int pa, input bit gp, input bit st, input bit sq);
    reqack_mode = ra; respack_mode = pa; gaps = gp; stray = st; seq_data = sq;
    stop_after = 0; resp_beats = 0; stall_seen = 0; respack_seen = 0; stray_seen = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reqcyc = 2'b11; respack = 2'b11; bus_reqack = 1'b1; bus_respcyc = 1'b1;
      req[0] = {$urandom, $urandom}; req[1] = {$urandom, $urandom};
      reqtag[0] = T'($urandom); reqtag[1] = T'($urandom); bus_resp = {$urandom, $urandom};
      #1;
      checks++;
      if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (all_out !== '0) begin failures++; $display("FAIL post_reset_outputs got=%h exp=0", all_out); end
    end
  endtask

  task automatic test_fetch_read();
    set_modes(0, 0, 0, 0, 1);
    issue(I, 1, 64'h1000, 0);
    run(60, 0);
    checks++;
    if (phase[I] != P_DONE) begin failures++; $display("FAIL fetch_timeout phase=%0d exp done", phase[I]); end
    checks++;
    if (grant_req !== 64'h1000) begin failures++; $display("FAIL fetch_addr got=%h exp=1000", grant_req); end
    checks++;
    if (got[I].size() != LB || got[D].size() != 0) begin
      failures++; $display("FAIL fetch_beats got i=%0d d=%0d exp 8 0", got[I].size(), got[D].size());
    end
    for (int k = 0; k < got[I].size(); k++) begin
      checks++;
      if (got[I][k] !== W'(k)) begin failures++; $display("FAIL fetch_data beat=%0d got=%h exp=%0d", k, got[I][k], k); end
    end
    run(10, 1);
    checks++;
    if (g_now !== 2'b00 || bus_reqcyc !== 1'b0) begin
      failures++; $display("FAIL fetch_idle grant=%b reqcyc=%b exp 0", g_now, bus_reqcyc);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_modes(0, 0, 0, 0, 0);
    grant_log.delete(); grant_cyc.delete(); fin_log.delete();
    issue(I, 1, 64'h3000, 0);
    issue(D, 1, 64'h4000, 0);
    run(100, 0);
    issue(I, 1, 64'h3040, 0);
    issue(D, 1, 64'h4040, 0);
    run(100, 0);
    checks++;
    if (grant_log.size() != 4) begin
      failures++; $display("FAIL simul_grants got=%0d exp=4", grant_log.size());
    end else begin
      checks++;
      if (grant_log[0] != I || grant_log[1] != D || grant_log[2] != I || grant_log[3] != D) begin
        failures++;
        $display("FAIL simul_order got=%0d%0d%0d%0d exp=0101", grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
      end
      checks++;
      if (grant_cyc[1] - fin_log[0] != 2) begin
        failures++; $display("FAIL simul_gap got=%0d exp=2", grant_cyc[1] - fin_log[0]);
      end
    end
  endtask

  task automatic test_write();
    set_modes(1, 0, 0, 0, 0);
    issue(D, 0, 64'h2000, 0);
    for (int k = 0; k < LB; k++) wdat[D][k] = W'(8'hA0 + k);
    run(80, 0);
    checks++;
    if (phase[D] != P_DONE) begin failures++; $display("FAIL write_timeout phase=%0d exp done", phase[D]); end
    checks++;
    if (wlog[D].size() != LB) begin failures++; $display("FAIL write_beats got=%0d exp=8", wlog[D].size()); end
    for (int k = 0; k < wlog[D].size(); k++) begin
      checks++;
      if (wlog[D][k] !== W'(8'hA0 + k)) begin
        failures++; $display("FAIL write_data beat=%0d got=%h exp=%h", k, wlog[D][k], 8'hA0 + k);
      end
    end
    checks++;
    if (respack_seen != 0) begin failures++; $display("FAIL write_respack got=%0d exp=0", respack_seen); end
  endtask

  task automatic test_backpressure();
    set_modes(0, 1, 0, 0, 1);
    issue(I, 1, 64'h5000, 0);
    run(80, 0);
    checks++;
    if (phase[I] != P_DONE || got[I].size() != LB) begin
      failures++; $display("FAIL bp_done phase=%0d beats=%0d exp done 8", phase[I], got[I].size());
    end
    checks++;
    if (stall_seen != 3) begin failures++; $display("FAIL bp_stall got=%0d exp=3", stall_seen); end
    for (int k = 0; k < got[I].size(); k++) begin
      checks++;
      if (got[I][k] !== W'(k)) begin failures++; $display("FAIL bp_data beat=%0d got=%h exp=%0d", k, got[I][k], k); end
    end
  endtask

  task automatic test_reset_mid();
    set_modes(0, 0, 0, 0, 1);
    issue(I, 1, 64'h6000, 0);
    stop_after = 3;
    run(60, 0);
    checks++;
    if (resp_beats != 3) begin failures++; $display("FAIL rmid_beats got=%0d exp=3", resp_beats); end
    @(negedge clk);
    #1;
    checks++;
    if (i_busgrant !== 1'b1) begin failures++; $display("FAIL rmid_busy got=%b exp=1", i_busgrant); end
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL rmid_outputs got=%h exp=0", all_out); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    set_modes(0, 0, 0, 0, 1);
    issue(I, 1, 64'h6100, 1);
    run(60, 0);
    checks++;
    if (phase[I] != P_DONE || got[I].size() != LB || resp_beats != LB) begin
      failures++; $display("FAIL rmid_after phase=%0d beats=%0d exp done 8", phase[I], got[I].size());
    end
  endtask

  task automatic test_stray();
    set_modes(0, 0, 0, 1, 0);
    run(20, 20);
    checks++;
    if (stray_seen == 0 || respack_seen != 0) begin
      failures++; $display("FAIL stray stray_beats=%0d respack=%0d exp >0 0", stray_seen, respack_seen);
    end
  endtask

  task automatic test_random();
    int mask;
    for (int it = 0; it < 25; it++) begin
      set_modes(2, 2, 1, 1, 0);
      mask = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++)
        if (mask[m]) issue(m, 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 3));
      run(400, 0);
      for (int m = 0; m < 2; m++) if (mask[m]) begin
        int bad;
        bad = 0;
        if (rd[m]) begin
          if (got[m].size() != LB || exp_r[m].size() != LB) bad = 1;
          else for (int k = 0; k < LB; k++) if (got[m][k] !== exp_r[m][k]) bad = 1;
        end else begin
          if (wlog[m].size() != LB) bad = 1;
          else for (int k = 0; k < LB; k++) if (wlog[m][k] !== wdat[m][k]) bad = 1;
        end
        checks++;
        if (phase[m] != P_DONE || bad != 0) begin
          failures++;
          $display("FAIL random it=%0d m=%0d rd=%0d phase=%0d rbeats=%0d wbeats=%0d exp done 8 matching",
                   it, m, rd[m], phase[m], got[m].size(), wlog[m].size());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_write();
    test_backpressure();
    test_reset_mid();
    test_stray();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sysbus_mux.md
# sysbus_mux

Two-master system-bus multiplexer between the instruction-fetch unit, the data-memory unit and the single external system bus of the core. It arbitrates round-robin, forwards the winner's request beats, and steers response beats back to the owner. The owner keeps the bus for one complete transaction:

- a read is an address beat plus `LINE_BEATS` response beats;
- a write is an address beat plus `LINE_BEATS` data beats.

With this block, the fetch and memory stages never drive the external bus directly.

## Interface
Parameters:
- `BUS_DATA_WIDTH`, 64, width of request/response data
- `BUS_TAG_WIDTH`, 13, tag width; tag MSB = 1 means read, 0 means write
- `LINE_BEATS`, 8, data beats per transaction

Ports (`m` = `i` for fetch, `d` for memory):
- `clk` in 1: clock; one clock domain.
- `reset` in 1: asynchronous, active-high.
- `m_reqcyc` in 1: master request valid. Held, with `m_req` and `m_reqtag` stable, until `m_reqack`.
- `m_req` in `BUS_DATA_WIDTH`: address beat, then write data beats.
- `m_reqtag` in `BUS_TAG_WIDTH`: transaction tag; sampled on the address beat only.
- `m_reqack` out 1: request beat accepted.
- `m_respcyc` out 1: response beat valid to the master.
- `m_resp` out `BUS_DATA_WIDTH`: response data (broadcast copy of `bus_resp`).
- `m_resptag` out `BUS_TAG_WIDTH`: response tag (broadcast copy of `bus_resptag`).
- `m_respack` in 1: master accepts the response beat.
- `m_busgrant` out 1: the master owns the bus.
- `bus_reqcyc` out 1: external request valid.
- `bus_req` out `BUS_DATA_WIDTH`: external request data.
- `bus_reqtag` out `BUS_TAG_WIDTH`: external request tag.
- `bus_reqack` in 1: external request beat accepted.
- `bus_respcyc` in 1: external response beat valid.
- `bus_resp` in `BUS_DATA_WIDTH`: external response data.
- `bus_resptag` in `BUS_TAG_WIDTH`: external response tag.
- `bus_respack` out 1: response beat accepted.

## Operation
- **State machine states:** IDLE, ADDR, WDATA, RESP.
- **Registers:** `owner` (I/D), `last` (I/D, round-robin pointer), `is_read`, beat counter `cnt` of width clog2(`LINE_BEATS`)+1.
- **IDLE → ADDR (grant):**
  - If exactly one `m_reqcyc` is high, grant that master.
  - If both are high, grant the master that is not `last`.
  - On grant: `owner` ← winner, `last` ← winner, `cnt` ← 0.
- **ADDR:**
  - `bus_reqcyc`, `bus_req` and `bus_reqtag` carry the owner's signals; the non-owner's signals are ignored.
  - `owner_reqack` = `bus_reqack`.
  - When `bus_reqack` is high: `is_read` ← `bus_reqtag` MSB. Go to RESP if read, WDATA if write.
- **WDATA:**
  - Owner's beats pass through as in ADDR.
  - Each `bus_reqcyc` && `bus_reqack` increments `cnt`.
  - The beat that makes `cnt` = `LINE_BEATS` → IDLE. No response phase for writes.
- **RESP:**
  - `owner_respcyc` = `bus_respcyc`; `bus_respack` = `owner_respack`; the non-owner's `respcyc` is 0.
  - Each `bus_respcyc` && `bus_respack` increments `cnt`.
  - The beat that makes `cnt` = `LINE_BEATS` → IDLE.
- **Outside ADDR/WDATA:** `bus_reqcyc` = 0, and `bus_req`/`bus_reqtag` = 0.
- **Outside RESP:** `bus_respack` = 0 and both `m_respcyc` = 0. Stray response beats are not acknowledged.
- **Grants:** `m_busgrant` is high from ADDR entry through the cycle before returning to IDLE.
- **Mid-transaction requests:** a master that raises `m_reqcyc` while the other owns the bus waits with `reqack` = 0; no request is dropped.
- **Reset:** asserting reset mid-transaction aborts it immediately. State ← IDLE, `cnt` ← 0, `last` ← D, so the first simultaneous request goes to I.

## Timing
- **Reset values:** every output is 0 during and after reset until the first grant.
- **Grant latency:** `m_reqcyc` sampled in IDLE at edge N; `bus_reqcyc` and `m_busgrant` are high in cycle N+1.
- **Datapath:** the request/response datapath is combinational (mux only) once in ADDR/WDATA/RESP. `m_reqack` and `m_respcyc` arrive in the same cycle as the corresponding bus signal.
- **Bus turnaround:** after the final beat, the FSM is in IDLE for at least one cycle before the next grant.
- **Minimum transaction length:** read = 1 + 1 + `LINE_BEATS` + 1 cycles (grant cycle, address beat, response beats, IDLE turnaround).
- **Stalls:** `bus_reqack` low or `owner_respack` low stalls the transaction indefinitely; `cnt` counts only handshaken beats.
- **Simultaneous events:** a request from the other master in the final-beat cycle is granted at the next IDLE evaluation.

## Test plan
- **Single fetch read:** `i_reqcyc`, tag MSB = 1, address 0x1000; memory returns 8 beats 0x0…0x7.
  - Required: `bus_req` = 0x1000 the cycle after the request.
  - Required: `i_respcyc` high for exactly 8 handshaken beats; `d_respcyc` stays 0; then IDLE.
- **Simultaneous requests after reset:** `i_reqcyc` and `d_reqcyc` both high.
  - Required: I is granted first; D is granted after I's 8th response beat plus one IDLE cycle.
  - Next simultaneous pair → I again, since `last` = D.
- **Data write:** D issues address 0x2000 with tag MSB = 0, then 8 data beats 0xA0…0xA7; `bus_reqack` is low every other cycle.
  - Required: all 8 beats appear on `bus_req` in order; `d_reqack` mirrors `bus_reqack`.
  - Required: no `bus_respack` is issued; IDLE after the 8th accepted beat.
- **Response backpressure:** during a fetch read, `i_respack` is held low for 3 cycles on beat 4.
  - Required: `bus_respack` stays 0 for those cycles; `cnt` holds at 3; the transaction completes after 8 acked beats.
- **Reset mid-read:** assert `reset` after 3 response beats.
  - Required: all outputs 0 immediately; state IDLE.
  - Required: the next request is granted normally, with a fresh 8-beat count.
- **Stray response:** `bus_respcyc` high while in IDLE.
  - Required: `bus_respack` = 0 and both `m_respcyc` = 0.
